dmem_copy_engine: RTL and testbench
===================================

# dmem_copy_engine

Bus-initiator block that drives the data-memory port (the same addr / write_data / memwrite / memread / read_data / sign_mask / clk_stall interface the data memory presents to the CPU) to perform word-granular block copy and block fill without CPU involvement. It sits beside the processor in the top level, behind a 2:1 port mux that hands it the data-memory port while busy. It runs the full request/stall handshake itself instead of relying on processor clock gating.

## Interface
- SIGN_MASK_WORD, 4'b0100: sign_mask code driven on every access; selects a 32-bit unsigned word access.
- LEN_W, 16: width of the word-count field.
- clk  in  1  engine clock, same clock as the data memory.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0 = copy src→dst, 1 = fill dst with fill_pattern.
- src_addr  in  32  source byte address (copy only).
- dst_addr  in  32  destination byte address.
- len_words  in  LEN_W  number of 32-bit words to transfer.
- fill_pattern  in  32  word written in fill mode.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at completion, normal or error.
- err  out  1  set with done when the command was rejected; cleared on next accepted start.
- mem_addr  out  32  data-memory address.
- mem_write_data  out  32  data-memory write data.
- mem_memwrite  out  1  write request.
- mem_memread  out  1  read request.
- mem_sign_mask  out  4  constant SIGN_MASK_WORD.
- mem_read_data  in  32  data-memory read data.
- mem_clk_stall  in  1  responder busy.

## Operation
- All outputs are registered. Reset values: busy=0, done=0, err=0, mem_addr=0, mem_write_data=0, mem_memwrite=0, mem_memread=0, mem_sign_mask=SIGN_MASK_WORD. FSM resets to IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FIN.
- IDLE + start: latch src, dst, len, mode, and pattern.
  - src[1:0]≠0 (copy mode) or dst[1:0]≠0: go to FIN with err=1; no memory access.
  - len=0: go to FIN with err=0.
  - Otherwise: copy → RD_REQ, fill → WR_REQ.
- Handshake contract: a request (memread or memwrite with addr/data) is raised in the REQ state and held stable through WAIT. The responder asserts mem_clk_stall no later than the cycle after the request is raised. The access completes in the first WAIT cycle where mem_clk_stall=0. For reads, mem_read_data is captured in that cycle.
- RD_REQ→RD_WAIT unconditionally. RD_WAIT holds while stall=1. On completion it captures data into mem_write_data and goes to WR_REQ.
- WR_REQ→WR_WAIT. On WR_WAIT completion:
  - decrement the remaining count;
  - advance src and dst by 4 (32-bit wrap-around, no error);
  - if the count is now 0, go to FIN; else go to RD_REQ (copy) or WR_REQ (fill).
- memread and memwrite are never high together. Both are dropped in the completion cycle's next state unless an immediate new REQ follows.
- FIN: done=1 for exactly one cycle, busy falls in the same cycle, then IDLE.
- start while busy is ignored, not queued.
- Overlapping regions: strictly ascending-address order. dst>src overlap is therefore destructive by definition.
- rst_n low mid-transfer: immediately aborts, outputs take their reset values, and no done pulse is produced.

## Timing
- Start accepted at cycle 0; busy=1 from cycle 1.
- With no stall, each access takes 2 cycles (REQ, WAIT).
  - Copy of N words: done pulses at cycle 4N+1.
  - Fill of N words: done pulses at cycle 2N+1.
- Each responder stall cycle adds exactly one cycle.
- Rejected or zero-length command: done (and err if applicable) at cycle 1.
- mem_addr changes only on entry to a REQ state.

## Structure
- Shared package/defines file holds the FSM state encodings, MODE_COPY/MODE_FILL, and the word-access sign_mask constant, alongside the existing rv32i defines.
- A single module is sufficient. The port mux arbitrating CPU and engine access is a separate top-level concern and is not part of this block.

## Test plan
- Copy: src=0x100, dst=0x200, len=3, zero-stall memory preloaded with 0xA, 0xB, 0xC → dst holds 0xA, 0xB, 0xC; done at cycle 13; err=0.
- Fill: dst=0x40, len=4, pattern=0xDEADBEEF, responder stalling 2 cycles per access → 4 writes of 0xDEADBEEF to 0x40..0x4C; done at cycle 17.
- Misaligned dst=0x202 → done and err at cycle 1; no memread/memwrite ever asserted. len=0 → done at cycle 1 with err=0.
- start re-pulsed during a len=2 copy → ignored; exactly 2 reads and 2 writes occur; a single done pulse.
- rst_n asserted during the RD_WAIT of word 2 of 4 → all outputs return to reset values asynchronously; word 2 is never written; no done; a fresh start after release works.
- dst=0xFFFFFFFC, len=2 fill → writes at 0xFFFFFFFC then 0x00000000; err=0.

Source files
------------

// File: rtl/dmem_copy_engine_pkg.sv
// Shared types and constants for the data-memory block copy/fill engine.
package dmem_copy_engine_pkg;

  localparam int          LEN_W          = 16;
  localparam logic [3:0]  SIGN_MASK_WORD = 4'b0100;
  localparam logic        MODE_COPY      = 1'b0;
  localparam logic        MODE_FILL      = 1'b1;
  localparam logic [31:0] WORD_BYTES     = 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_FIN
  } state_e;

  // Latched command; len counts down as words retire.
  typedef struct packed {
    logic             mode;
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [LEN_W-1:0] len;
    logic [31:0]      pattern;
  } cmd_t;

  // Source alignment only matters when the source is actually read.
  function automatic logic cmd_misaligned(input cmd_t c);
    return (c.dst[1:0] != 2'b00) || ((c.mode == MODE_COPY) && (c.src[1:0] != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_copy_engine_if.sv
// Data-memory port bundle: request side driven by the engine, stall/data by memory.
interface dmem_copy_engine_if;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        memwrite;
  logic        memread;
  logic [3:0]  sign_mask;
  logic [31:0] read_data;
  logic        clk_stall;

  modport master (
    output addr, write_data, memwrite, memread, sign_mask,
    input  read_data, clk_stall
  );

  modport slave (
    input  addr, write_data, memwrite, memread, sign_mask,
    output read_data, clk_stall
  );
endinterface

// File: rtl/dmem_copy_engine.sv
// Word-granular block copy / fill initiator on the data-memory port.
// Runs the request/stall handshake itself; every output is a register.
module dmem_copy_engine
  import dmem_copy_engine_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                mode,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_W-1:0]    len_words,
  input  logic [31:0]         fill_pattern,
  output logic                busy,
  output logic                done,
  output logic                err,
  dmem_copy_engine_if.master  mem
);

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d, cmd_in;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  assign cmd_in = '{mode, src_addr, dst_addr, len_words, fill_pattern};

  // Outputs are computed for the state being entered, so each request
  // appears together with its REQ state and stays put through WAIT.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cmd_d = cmd_in;
          err_d = 1'b0;
          if (cmd_misaligned(cmd_in)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else if (cmd_in.len == '0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
          end else if (cmd_in.mode == MODE_COPY) begin
            state_d = S_RD_REQ;
            busy_d  = 1'b1;
            rd_d    = 1'b1;
            addr_d  = cmd_in.src;
          end else begin
            state_d = S_WR_REQ;
            busy_d  = 1'b1;
            wr_d    = 1'b1;
            addr_d  = cmd_in.dst;
            wdata_d = cmd_in.pattern;
          end
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_WAIT;
        rd_d    = 1'b1;
      end
      S_RD_WAIT: begin
        if (mem.clk_stall) begin
          rd_d = 1'b1;
        end else begin
          state_d = S_WR_REQ;
          wr_d    = 1'b1;
          addr_d  = cmd_q.dst;
          wdata_d = mem.read_data;
        end
      end
      S_WR_REQ: begin
        state_d = S_WR_WAIT;
        wr_d    = 1'b1;
      end
      S_WR_WAIT: begin
        if (mem.clk_stall) begin
          wr_d = 1'b1;
        end else begin
          cmd_d.len = cmd_q.len - LEN_W'(1);
          cmd_d.src = cmd_q.src + WORD_BYTES;
          cmd_d.dst = cmd_q.dst + WORD_BYTES;
          if (cmd_q.len == LEN_W'(1)) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (cmd_q.mode == MODE_COPY) begin
            state_d = S_RD_REQ;
            rd_d    = 1'b1;
            addr_d  = cmd_d.src;
          end else begin
            state_d = S_WR_REQ;
            wr_d    = 1'b1;
            addr_d  = cmd_d.dst;
            wdata_d = cmd_q.pattern;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign mem.addr       = addr_q;
  assign mem.write_data = wdata_q;
  assign mem.memread    = rd_q;
  assign mem.memwrite   = wr_q;
  assign mem.sign_mask  = SIGN_MASK_WORD;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Scoreboard bench: commands push expected accesses/done events, a responder
// process plays the stalling data memory and checks what the engine does.
module tb_dmem_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n, start, mode;
  logic [31:0] src_addr, dst_addr, fill_pattern;
  logic [15:0] len_words;
  logic        busy, done, err;

  dmem_copy_engine_if mem_if();

  dmem_copy_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len_words    (len_words),
    .fill_pattern (fill_pattern),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem          (mem_if)
  );

  always #5 clk = ~clk;

  typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } acc_t;
  typedef struct { int cyc; bit err; } done_t;

  acc_t        exp_acc[$];
  done_t       exp_done[$];
  logic [31:0] mem_model [logic [31:0]];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          stall_k = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bg(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction

  function automatic logic [31:0] peek(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : bg(a);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Memory responder + monitor: first request cycle is REQ, then stall_k
  // stall cycles, then the completing cycle.
  initial begin : responder
    int    age;
    int    left;
    acc_t  e;
    done_t d;
    age = 0;
    left = 0;
    mem_if.clk_stall = 1'b0;
    mem_if.read_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        age = 0;
        left = 0;
        mem_if.clk_stall = 1'b0;
      end else begin
        chk("sign_mask", 32'(mem_if.sign_mask), 32'h4);
        chk("rd_wr_exclusive", 32'(mem_if.memread & mem_if.memwrite), 32'h0);
        mem_if.read_data = peek(mem_if.addr);
        if (!(mem_if.memread || mem_if.memwrite)) begin
          age = 0;
          mem_if.clk_stall = 1'b0;
        end else if (age == 0) begin
          age = 1;
          left = stall_k;
          mem_if.clk_stall = 1'b0;
        end else if (left > 0) begin
          left--;
          mem_if.clk_stall = 1'b1;
        end else begin
          age = 0;
          mem_if.clk_stall = 1'b0;
          if (exp_acc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_access addr=0x%08h wr=%0b required=none",
                     mem_if.addr, mem_if.memwrite);
          end else begin
            e = exp_acc.pop_front();
            chk("acc_kind", 32'(mem_if.memwrite), 32'(e.wr));
            chk("acc_addr", mem_if.addr, e.addr);
            if (e.wr) chk("acc_wdata", mem_if.write_data, e.data);
          end
          if (mem_if.memwrite) mem_model[mem_if.addr] = mem_if.write_data;
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done cycle=%0d required=none", cyc);
          end else begin
            d = exp_done.pop_front();
            chk("done_cycle", 32'(cyc), 32'(d.cyc));
            chk("done_err", 32'(err), 32'(d.err));
            chk("busy_at_done", 32'(busy), 32'h0);
          end
        end
      end
    end
  end

  // Caller must be sitting on a negedge.
  task automatic pulse(input bit m, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] n, input logic [31:0] p);
    mode = m; src_addr = s; dst_addr = d; len_words = n; fill_pattern = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Expected behaviour from the rules: ascending word order, reads see earlier
  // writes of the same command; latency 1 + accesses*(2+stall).
  task automatic issue(input bit m, input logic [31:0] s, input logic [31:0] d,
                       input logic [15:0] n, input logic [31:0] p, input int k);
    logic [31:0] sh [logic [31:0]];
    logic [31:0] v, sa, da;
    bit          bad;
    int          lat;
    done_t       dn;
    @(negedge clk);
    bad = (d[1:0] != 2'b00) || (!m && (s[1:0] != 2'b00));
    stall_k = k;
    if (bad || n == 0) lat = 1;
    else               lat = 1 + (m ? int'(n) : 2 * int'(n)) * (2 + k);
    if (!bad) begin
      sh = mem_model;
      for (int i = 0; i < int'(n); i++) begin
        sa = s + (32'(i) << 2);
        da = d + (32'(i) << 2);
        if (m) v = p;
        else begin
          v = sh.exists(sa) ? sh[sa] : bg(sa);
          exp_acc.push_back('{1'b0, sa, v});
        end
        sh[da] = v;
        exp_acc.push_back('{1'b1, da, v});
      end
    end
    dn.cyc = cyc + lat;
    dn.err = bad;
    exp_done.push_back(dn);
    pulse(m, s, d, n, p);
    chk("busy_after_start", 32'(busy), 32'(lat > 1));
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (exp_done.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (exp_done.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout pending_done=%0d required=0", nm, exp_done.size());
      exp_done.delete();
    end
    chk({nm, "_accesses_left"}, 32'(exp_acc.size()), 32'h0);
    exp_acc.delete();
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_busy"},      32'(busy), 32'h0);
    chk({nm, "_done"},      32'(done), 32'h0);
    chk({nm, "_err"},       32'(err), 32'h0);
    chk({nm, "_addr"},      mem_if.addr, 32'h0);
    chk({nm, "_wdata"},     mem_if.write_data, 32'h0);
    chk({nm, "_memwrite"},  32'(mem_if.memwrite), 32'h0);
    chk({nm, "_memread"},   32'(mem_if.memread), 32'h0);
    chk({nm, "_sign_mask"}, 32'(mem_if.sign_mask), 32'h4);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog_timeout time=%0t required=finish", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin : main
    int t;
    rst_n = 1'b0; start = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; len_words = '0; fill_pattern = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed copy from preloaded memory
    mem_model[32'h100] = 32'hA;
    mem_model[32'h104] = 32'hB;
    mem_model[32'h108] = 32'hC;
    issue(1'b0, 32'h100, 32'h200, 16'd3, 32'h0, 0);
    wait_done("copy3");
    chk("copy3_w0", peek(32'h200), 32'hA);
    chk("copy3_w1", peek(32'h204), 32'hB);
    chk("copy3_w2", peek(32'h208), 32'hC);

    // Fill with a 2-cycle stall per access
    issue(1'b1, 32'h0, 32'h40, 16'd4, 32'hDEADBEEF, 2);
    wait_done("fill4");
    for (int i = 0; i < 4; i++) chk("fill4_mem", peek(32'h40 + 32'(4 * i)), 32'hDEADBEEF);

    // Rejected and empty commands
    issue(1'b0, 32'h100, 32'h202, 16'd3, 32'h0, 0);
    wait_done("misaligned");
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'h1);
    issue(1'b1, 32'h0, 32'h80, 16'd0, 32'h1234, 0);
    wait_done("len0");

    // start during a transfer is ignored
    issue(1'b0, 32'h100, 32'h500, 16'd2, 32'h0, 1);
    repeat (2) @(negedge clk);
    pulse(1'b1, 32'h0, 32'h600, 16'd5, 32'h55);
    wait_done("repulse");
    chk("repulse_no_fill", 32'(mem_model.exists(32'h600)), 32'h0);

    // Reset during RD_WAIT of word 2 of 4
    issue(1'b0, 32'h300, 32'h400, 16'd4, 32'h0, 2);
    t = 0;
    while (!(exp_acc.size() == 6 && mem_if.memread === 1'b1) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("reset_test_reached_word2", 32'(t < 500), 32'h1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    exp_acc.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("word1_written", peek(32'h400), bg(32'h300));
    chk("word2_not_written", 32'(mem_model.exists(32'h404)), 32'h0);
    issue(1'b0, 32'h300, 32'h400, 16'd4, 32'h0, 0);
    wait_done("after_reset");

    // Address wrap-around
    issue(1'b1, 32'h0, 32'hFFFFFFFC, 16'd2, 32'hCAFEF00D, 0);
    wait_done("wrap");
    chk("wrap_top", peek(32'hFFFFFFFC), 32'hCAFEF00D);
    chk("wrap_zero", peek(32'h0), 32'hCAFEF00D);

    // Random commands over a small region so copies overlap
    for (int r = 0; r < 14; r++) begin
      bit          m;
      logic [31:0] s, d;
      logic [15:0] n;
      int          k;
      m = 1'($urandom_range(1, 0));
      s = 32'h1000 + (32'($urandom_range(0, 31)) << 2);
      d = 32'h1000 + (32'($urandom_range(0, 31)) << 2);
      if ($urandom_range(0, 7) == 0) s = s + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) d = d + 32'($urandom_range(1, 3));
      n = 16'($urandom_range(0, 6));
      k = int'($urandom_range(0, 2));
      issue(m, s, d, n, $urandom, k);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
